// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the branch predictor: counter encodings,
// delay-slot offset and default table geometry.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   localparam int          DEFAULT_INDEX_W   = 6;
   localparam int          DEFAULT_TAG_W     = 8;
   localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

endpackage

// File: rtl/bpred_sat_ctr.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bpred_sat_ctr
   import branch_predictor_pkg::*;
(
   input  ctr_t ctr,
   input  logic taken,
   output ctr_t ctr_next
);

   always_comb begin
      ctr_next = ctr;
      unique case (ctr)
         CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
         default: ctr_next = ctr;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, combinational lookup and registered
// mispredict redirect. Optional statistics counters under `BPRED_STATS_EN.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_W = DEFAULT_INDEX_W,
   parameter int TAG_W   = DEFAULT_TAG_W
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_branch,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred,
   output logic [31:0] stat_hits
`endif
);

   localparam int ENTRIES = 1 << INDEX_W;
   localparam int TAG_LO  = INDEX_W + 2;
   localparam int TAG_HI  = INDEX_W + TAG_W + 1;

   logic [ENTRIES-1:0] valid_vec;
   logic [TAG_W-1:0]   tag_vec    [ENTRIES];
   ctr_t               ctr_vec    [ENTRIES];
   logic [31:0]        target_vec [ENTRIES];

   logic [INDEX_W-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               upd_hit;
   logic               alloc;
   logic               train;
   logic               inval;
   ctr_t               ctr_next;
   logic               mis;
   logic [31:0]        correct_pc;
   logic               redirect_valid_reg;
   logic [31:0]        redirect_pc_reg;
   logic               unused_pc_bits;

   assign lk_idx  = lookup_pc[INDEX_W+1:2];
   assign lk_tag  = lookup_pc[TAG_HI:TAG_LO];
   assign upd_idx = upd_pc[INDEX_W+1:2];
   assign upd_tag = upd_pc[TAG_HI:TAG_LO];

   assign unused_pc_bits = &{lookup_pc[31:TAG_HI+1], lookup_pc[1:0]};

   // Lookup reads the pre-edge table, so same-cycle updates are invisible here.
   assign pred_hit    = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag);
   assign pred_taken  = pred_hit && ctr_vec[lk_idx][1];
   assign pred_target = pred_hit ? target_vec[lk_idx] : 32'd0;

   assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
   assign alloc   = upd_valid && upd_is_branch && !upd_hit && upd_taken;
   assign train   = upd_valid && upd_is_branch && upd_hit;
   assign inval   = upd_valid && !upd_is_branch && upd_hit;

   bpred_sat_ctr u_sat_ctr (
      .ctr      (ctr_vec[upd_idx]),
      .taken    (upd_taken),
      .ctr_next (ctr_next)
   );

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic             valid_reg;
         logic [TAG_W-1:0] tag_reg;
         ctr_t             ctr_reg;
         logic [31:0]      target_reg;
         logic             sel;

         assign sel = (upd_idx == INDEX_W'(gi));

         always_ff @(posedge clk) begin
            if (!resetn) begin
               valid_reg <= 1'b0;
               ctr_reg   <= CTR_WNT;
            end else if (sel) begin
               if (alloc) begin
                  valid_reg <= 1'b1;
                  ctr_reg   <= CTR_WT;
               end else if (train) begin
                  ctr_reg <= ctr_next;
               end else if (inval) begin
                  valid_reg <= 1'b0;
               end
            end
         end

         // Tag and target carry no reset; valid gates their use.
         always_ff @(posedge clk) begin
            if (resetn && sel && (alloc || (train && upd_taken)))
               target_reg <= upd_target;
            if (resetn && sel && alloc)
               tag_reg <= upd_tag;
         end

         assign valid_vec[gi]  = valid_reg;
         assign tag_vec[gi]    = tag_reg;
         assign ctr_vec[gi]    = ctr_reg;
         assign target_vec[gi] = target_reg;
      end
   endgenerate

   always_comb begin
      mis = 1'b0;
      if (upd_valid) begin
         if (upd_is_branch)
            mis = (upd_pred_taken != upd_taken) ||
                  (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
         else
            mis = upd_pred_taken;
      end
      correct_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + DELAY_SLOT_OFFSET;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= 32'd0;
      end else begin
         redirect_valid_reg <= mis;
         if (mis)
            redirect_pc_reg <= correct_pc;
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;

`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches_reg;
   logic [31:0] stat_mispred_reg;
   logic [31:0] stat_hits_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_branches_reg <= 32'd0;
         stat_mispred_reg  <= 32'd0;
         stat_hits_reg     <= 32'd0;
      end else begin
         if (upd_valid && upd_is_branch)
            stat_branches_reg <= stat_branches_reg + 32'd1;
         if (mis)
            stat_mispred_reg <= stat_mispred_reg + 32'd1;
         if (upd_valid && upd_pred_taken)
            stat_hits_reg <= stat_hits_reg + 32'd1;
      end
   end

   assign stat_branches = stat_branches_reg;
   assign stat_mispred  = stat_mispred_reg;
   assign stat_hits     = stat_hits_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a table-level reference model.
module tb_branch_predictor;

   logic        clk;
   logic        resetn;
   logic [31:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_branch;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;
   logic [31:0] stat_hits;
`endif

   branch_predictor dut (
      .clk             (clk),
      .resetn          (resetn),
      .lookup_pc       (lookup_pc),
      .pred_hit        (pred_hit),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_branch   (upd_is_branch),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
`ifdef BPRED_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispred    (stat_mispred),
      .stat_hits       (stat_hits)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a 64-entry table with an integer counter per entry.
   bit          m_valid  [64];
   int          m_tag    [64];
   int          m_ctr    [64];
   logic [31:0] m_target [64];
   bit          m_rv;
   logic [31:0] m_rpc;
   logic [31:0] m_st_br;
   logic [31:0] m_st_mis;
   logic [31:0] m_st_hits;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Hand-computed pins for the directed phase.
   bit          pin_lk_en = 1'b0;
   bit          pin_hit;
   bit          pin_taken;
   logic [31:0] pin_target;
   bit          pin_rd_en = 1'b0;
   bit          pin_rv;
   logic [31:0] pin_rpc;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd64);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> 8) % 32'd256);
   endfunction

   function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                    output bit tk, output logic [31:0] tg);
      int i;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      tk  = hit && (m_ctr[i] >= 2);
      tg  = hit ? m_target[i] : 32'd0;
   endfunction

   task automatic model_step();
      if (!resetn) begin
         for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
         m_rv      = 1'b0;
         m_rpc     = 32'd0;
         m_st_br   = 32'd0;
         m_st_mis  = 32'd0;
         m_st_hits = 32'd0;
      end else begin
         bit mis;
         bit hit;
         int i;
         m_rv = 1'b0;
         if (upd_valid) begin
            i   = idx_of(upd_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
            if (upd_is_branch)
               mis = (upd_pred_taken != upd_taken) ||
                     (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
            else
               mis = upd_pred_taken;
            if (mis) begin
               m_rv  = 1'b1;
               m_rpc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd8;
               m_st_mis = m_st_mis + 32'd1;
            end
            if (upd_is_branch) m_st_br = m_st_br + 32'd1;
            if (upd_pred_taken) m_st_hits = m_st_hits + 32'd1;
            if (upd_is_branch) begin
               if (hit) begin
                  if (upd_taken) begin
                     m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                     m_target[i] = upd_target;
                  end else begin
                     m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                  end
               end else if (upd_taken) begin
                  m_valid[i]  = 1'b1;
                  m_tag[i]    = tag_of(upd_pc);
                  m_target[i] = upd_target;
                  m_ctr[i]    = 2;
               end
            end else if (hit) begin
               m_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: DUT vs model every cycle, plus literal pins.
   always @(negedge clk) begin
      bit          h;
      bit          t;
      logic [31:0] tg;
      if (chk_en) begin
         m_lookup(lookup_pc, h, t, tg);
         check("pred_hit", {31'd0, pred_hit}, {31'd0, h});
         check("pred_taken", {31'd0, pred_taken}, {31'd0, t});
         check("pred_target", pred_target, tg);
         check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
         check("redirect_pc", redirect_pc, m_rpc);
`ifdef BPRED_STATS_EN
         check("stat_branches", stat_branches, m_st_br);
         check("stat_mispred", stat_mispred, m_st_mis);
         check("stat_hits", stat_hits, m_st_hits);
`endif
         if (pin_lk_en) begin
            check("pin_hit", {31'd0, pred_hit}, {31'd0, pin_hit});
            check("pin_taken", {31'd0, pred_taken}, {31'd0, pin_taken});
            check("pin_target", pred_target, pin_target);
         end
         if (pin_rd_en) begin
            check("pin_redirect_valid", {31'd0, redirect_valid}, {31'd0, pin_rv});
            check("pin_redirect_pc", redirect_pc, pin_rpc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      pin_lk_en = 1'b0;
      pin_rd_en = 1'b0;
   endtask

   task automatic idle_upd();
      upd_valid       = 1'b0;
      upd_pc          = 32'd0;
      upd_is_branch   = 1'b0;
      upd_taken       = 1'b0;
      upd_target      = 32'd0;
      upd_pred_taken  = 1'b0;
      upd_pred_target = 32'd0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input bit br, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptg);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_is_branch   = br;
      upd_taken       = tk;
      upd_target      = tgt;
      upd_pred_taken  = ptk;
      upd_pred_target = ptg;
      $display("upd pc=%08h br=%0d tk=%0d tgt=%08h ptk=%0d ptg=%08h", pc, br, tk, tgt, ptk, ptg);
   endtask

   task automatic pin_lk(input bit h, input bit t, input logic [31:0] tg);
      pin_lk_en  = 1'b1;
      pin_hit    = h;
      pin_taken  = t;
      pin_target = tg;
   endtask

   task automatic pin_rd(input bit rv, input logic [31:0] rpc);
      pin_rd_en = 1'b1;
      pin_rv    = rv;
      pin_rpc   = rpc;
   endtask

   function automatic logic [31:0] gen_pc();
      logic [31:0] pc;
      pc        = $urandom;
      pc[15:8]  = 8'($urandom_range(1, 3));
      pc[7:2]   = 6'($urandom_range(0, 2) * 5);
      return pc;
   endfunction

   localparam logic [31:0] PC_A   = 32'hBFC00100;
   localparam logic [31:0] PC_AL  = 32'hBFC00200;
   localparam logic [31:0] TGT_A  = 32'hBFC00040;
   localparam logic [31:0] PC_A8  = 32'hBFC00108;

   initial begin
      resetn    = 1'b0;
      lookup_pc = 32'd0;
      idle_upd();
      tick();
      tick();

      // Reset state
      chk_en    = 1'b1;
      resetn    = 1'b1;
      lookup_pc = PC_A;
      pin_lk(0, 0, 32'd0);
      pin_rd(0, 32'd0);
      tick();
      // Allocate taken branch; same-cycle lookup still misses
      set_upd(PC_A, 1, 1, TGT_A, 0, 32'd0);
      pin_lk(0, 0, 32'd0);
      tick();
      idle_upd();
      pin_lk(1, 1, TGT_A);
      pin_rd(1, TGT_A);
      tick();
      // Not taken twice
      set_upd(PC_A, 1, 0, TGT_A, 1, TGT_A);
      pin_lk(1, 1, TGT_A);
      pin_rd(0, TGT_A);
      tick();
      set_upd(PC_A, 1, 0, TGT_A, 0, 32'd0);
      pin_lk(1, 0, TGT_A);
      pin_rd(1, PC_A8);
      tick();
      // Four taken from strongly not-taken
      set_upd(PC_A, 1, 1, TGT_A, 0, 32'd0);
      pin_lk(1, 0, TGT_A);
      pin_rd(0, PC_A8);
      tick();
      set_upd(PC_A, 1, 1, TGT_A, 0, 32'd0);
      pin_lk(1, 0, TGT_A);
      pin_rd(1, TGT_A);
      tick();
      set_upd(PC_A, 1, 1, TGT_A, 1, TGT_A);
      pin_lk(1, 1, TGT_A);
      pin_rd(1, TGT_A);
      tick();
      set_upd(PC_A, 1, 1, TGT_A, 1, TGT_A);
      pin_lk(1, 1, TGT_A);
      pin_rd(0, TGT_A);
      tick();
      // One not-taken from saturated state must still predict taken
      set_upd(PC_A, 1, 0, TGT_A, 1, TGT_A);
      pin_lk(1, 1, TGT_A);
      pin_rd(0, TGT_A);
      tick();
      // Alias with a different tag, not taken: no change
      set_upd(PC_AL, 1, 0, 32'h0, 0, 32'd0);
      pin_lk(1, 1, TGT_A);
      pin_rd(1, PC_A8);
      tick();
      // Non-branch hitting own tag invalidates and redirects to pc+8
      set_upd(PC_A, 0, 0, 32'h0, 1, TGT_A);
      lookup_pc = PC_AL;
      pin_lk(0, 0, 32'd0);
      pin_rd(0, PC_A8);
      tick();
      idle_upd();
      lookup_pc = PC_A;
      pin_lk(0, 0, 32'd0);
      pin_rd(1, PC_A8);
      tick();
      // Same-cycle lookup/update of index 0
      set_upd(PC_A, 1, 1, 32'h12345678, 0, 32'd0);
      pin_lk(0, 0, 32'd0);
      pin_rd(0, PC_A8);
      tick();
      // Wrong target with correct direction
      set_upd(PC_A, 1, 1, 32'hAAAA0000, 1, 32'h12345678);
      pin_lk(1, 1, 32'h12345678);
      pin_rd(1, 32'h12345678);
      tick();
      // Reset the cycle after a mispredict, with a competing update
      resetn = 1'b0;
      set_upd(32'hBFC00140, 1, 1, 32'h55550000, 0, 32'd0);
      pin_lk(1, 1, 32'hAAAA0000);
      pin_rd(1, 32'hAAAA0000);
      tick();
      resetn = 1'b1;
      idle_upd();
      lookup_pc = 32'hBFC00140;
      pin_lk(0, 0, 32'd0);
      pin_rd(0, 32'd0);
      tick();
      lookup_pc = PC_A;
      pin_lk(0, 0, 32'd0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         resetn    = ($urandom_range(0, 255) != 0);
         lookup_pc = gen_pc();
         if ($urandom_range(0, 9) < 7) begin
            bit          h;
            bit          t;
            logic [31:0] tg;
            logic [31:0] pc;
            logic [31:0] tgt;
            pc  = gen_pc();
            tgt = 32'h80000000 + 32'($urandom_range(0, 2)) * 32'h100;
            if ($urandom_range(0, 19) == 0) tgt = $urandom;
            m_lookup(pc, h, t, tg);
            upd_valid       = 1'b1;
            upd_pc          = pc;
            upd_is_branch   = ($urandom_range(0, 99) < 85);
            upd_taken       = $urandom_range(0, 1) != 0;
            upd_target      = tgt;
            if ($urandom_range(0, 9) < 7) begin
               upd_pred_taken  = t;
               upd_pred_target = tg;
            end else begin
               upd_pred_taken  = $urandom_range(0, 1) != 0;
               upd_pred_target = ($urandom_range(0, 1) != 0) ? tgt : $urandom;
            end
         end else begin
            idle_upd();
            upd_pc     = $urandom;
            upd_target = $urandom;
         end
         tick();
      end
      resetn = 1'b1;
      idle_upd();
      tick();
      #6;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
